wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//   Shares the single writeback port (register file / ROB result bus) among N execution units
//   (bypass, ALU, shift, logic, ...). Each unit owns a one-entry holding buffer. A round-robin
//   arbiter picks one full buffer per cycle into a registered writeback stage.
//   Sits between the execution units and the ROB/regfile write port.
// PARAMETERS
//   N_UNITS  4   number of execution units sharing the port (2..8)
//   DATA_W   32  result width
//   TAG_W    4   ROB tag width
// PORTS
//   clk          in   1               clock, rising edge
//   reset        in   1               asynchronous, active-low
//   flush        in   1               sync squash of all pending and staged results
//   unit_valid   in   N_UNITS         unit i presents a result
//   unit_result  in   N_UNITS*DATA_W  result of unit i, slice [i*DATA_W +: DATA_W]
//   unit_tag     in   N_UNITS*TAG_W   ROB tag of unit i, slice [i*TAG_W +: TAG_W]
//   unit_ready   out  N_UNITS         buffer i can accept this cycle
//   wb_valid     out  1               writeback stage holds a result
//   wb_data      out  DATA_W          result being written back
//   wb_tag       out  TAG_W           ROB tag of wb_data
//   wb_unit      out  $clog2(N_UNITS) index of the unit that produced wb_data
//   wb_ready     in   1               ROB/regfile consumes wb stage this cycle
// BEHAVIOUR
//   Reset: buf_v all 0, rr_ptr=0, wb_valid=0, wb_data=0, wb_tag=0, wb_unit=0; unit_ready all 1.
//   Input handshake: transfer into buf i at edge when unit_valid[i] && unit_ready[i].
//   wb_free = !wb_valid || wb_ready.
//   Arbitration (comb): if wb_free, grant the first i with buf_v[i], searching rr_ptr, rr_ptr+1,
//     ... mod N_UNITS; at most one grant; no grant when !wb_free or no buf_v set.
//   unit_ready[i] = !buf_v[i] || grant[i] (same-cycle refill of a draining buffer allowed).
//   On grant g at edge: wb_valid<=1, wb_data/wb_tag<=buf[g], wb_unit<=g, rr_ptr<=(g+1) mod N.
//   If wb_free and no grant: wb_valid<=0 (data/tag/unit hold last value).
//   If !wb_free: wb stage, buffers and rr_ptr hold; only empty buffers may load.
//   Buffer i next state: buf_v <= (buf_v && !grant[i]) || (unit_valid[i] && unit_ready[i]);
//     granted + new input same edge -> buffer reloads, stays full.
//   Latency: unit_valid at edge E0 -> wb_valid visible after E1 (2 edges, uncontended).
//   Throughput: 1 result/cycle total; every full buffer granted within N_UNITS wb cycles.
//   flush=1 at edge: buf_v<=0, wb_valid<=0, rr_ptr holds; inputs offered that cycle dropped;
//     flush has priority over all other updates. unit_ready still computed normally.
//   Reset asserted mid-operation: all state cleared immediately, pending results lost.
//   wb_valid && !wb_ready: wb_data/wb_tag/wb_unit stable until consumed (no bubbles lost).
// STRUCTURE
//   Package my_pkg: typedef wb_pkt_t {logic [DATA_W-1:0] data; logic [TAG_W-1:0] tag;};
//     unit index constants UNIT_BYPASS=0, UNIT_ALU=1, UNIT_SHIFT=2, UNIT_LOGIC=3; N_UNITS default.
//   Sub-module rr_arbiter #(N): req[N], ptr -> one-hot grant[N], grant_idx, any_grant;
//     purely combinational; wb_arbiter keeps rr_ptr, buffers and wb stage registers.
// TESTING
//   1 Reset then single unit 0 result 0xDEADBEEF tag 3 -> wb_valid 2 edges later, wb_unit=0,
//     wb_tag=3, unit_ready[0] stays 1.
//   2 All 4 units valid same cycle (data 0x10..0x13), wb_ready=1 -> wb order unit 0,1,2,3 on
//     4 consecutive cycles; rr_ptr=0 after; unit_ready[1..3] low until own grant.
//   3 Unit 2 streams every cycle with unit 1 also continuous, rr_ptr=2 -> grants alternate
//     2,1,2,1...; no unit starved; no result duplicated or dropped (scoreboard by tag).
//   4 wb_ready=0 for 3 cycles with wb_valid=1 -> wb_data/tag/unit stable 3 cycles, full
//     buffers hold, unit_ready low for full units; first cycle wb_ready=1 -> next grant.
//   5 Buffers 0,3 full, wb_valid=1, flush=1 plus unit_valid[1]=1 -> next cycle wb_valid=0,
//     all buf_v=0, unit 1 result never appears on wb.
//   6 Assert reset while 3 buffers full and wb_valid=1 -> outputs zero immediately; after
//     release first new input writes back with wb_unit equal to that unit.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter slice.
package wb_arbiter_pkg;

  localparam int unsigned N_UNITS_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TAG_W_DEF   = 4;

  // Fixed execution-unit slots on the shared writeback port.
  typedef enum logic [2:0] {
    UNIT_BYPASS = 3'd0,
    UNIT_ALU    = 3'd1,
    UNIT_SHIFT  = 3'd2,
    UNIT_LOGIC  = 3'd3
  } unit_id_e;

  // Writeback packet at the default widths.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [TAG_W_DEF-1:0]  tag;
  } wb_pkt_t;

  // Modulo-n reduction for values known to be below 2*n.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module rr_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any_grant
);

  logic [PW-1:0] cand;

  // Scan ptr, ptr+1, ... (mod N) and take the first request found.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = PW'(rr_wrap(32'(ptr) + off, N));
      if (!any_grant && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        any_grant   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback port sharing: one holding buffer per execution unit, a round-robin
// pick of one full buffer per cycle, and a registered writeback stage.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter  int unsigned N_UNITS = N_UNITS_DEF,
  parameter  int unsigned DATA_W  = DATA_W_DEF,
  parameter  int unsigned TAG_W   = TAG_W_DEF,
  localparam int unsigned UW      = $clog2(N_UNITS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [N_UNITS-1:0]        unit_valid,
  input  logic [N_UNITS*DATA_W-1:0] unit_result,
  input  logic [N_UNITS*TAG_W-1:0]  unit_tag,
  output logic [N_UNITS-1:0]        unit_ready,
  output logic                      wb_valid,
  output logic [DATA_W-1:0]         wb_data,
  output logic [TAG_W-1:0]          wb_tag,
  output logic [UW-1:0]             wb_unit,
  input  logic                      wb_ready
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } pkt_t;

  logic [N_UNITS-1:0] buf_v_q, buf_v_d;
  pkt_t               buf_q [N_UNITS];
  pkt_t               buf_d [N_UNITS];
  logic [UW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               wb_valid_q, wb_valid_d;
  pkt_t               wb_pkt_q, wb_pkt_d;
  logic [UW-1:0]      wb_unit_q, wb_unit_d;

  logic               wb_free;
  logic [N_UNITS-1:0] req;
  logic [N_UNITS-1:0] grant;
  logic [N_UNITS-1:0] load;
  logic [UW-1:0]      grant_idx;
  logic               any_grant;
  pkt_t               in_pkt [N_UNITS];

  // Slice the flat unit buses into per-unit packets.
  always_comb begin
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      in_pkt[i].data = unit_result[i*DATA_W +: DATA_W];
      in_pkt[i].tag  = unit_tag[i*TAG_W +: TAG_W];
    end
  end

  // Arbitration only runs when the writeback stage can take a new result.
  always_comb begin
    wb_free    = !wb_valid_q || wb_ready;
    req        = wb_free ? buf_v_q : '0;
    // A buffer being drained this cycle may be refilled in the same cycle.
    unit_ready = ~buf_v_q | grant;
    load       = unit_valid & unit_ready;
  end

  rr_arbiter #(
    .N (N_UNITS)
  ) u_rr (
    .req       (req),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Next state for buffers, pointer and writeback stage; flush overrides all.
  always_comb begin
    buf_v_d    = buf_v_q;
    buf_d      = buf_q;
    rr_ptr_d   = rr_ptr_q;
    wb_valid_d = wb_valid_q;
    wb_pkt_d   = wb_pkt_q;
    wb_unit_d  = wb_unit_q;
    if (flush) begin
      buf_v_d    = '0;
      wb_valid_d = 1'b0;
    end else begin
      buf_v_d = (buf_v_q & ~grant) | load;
      for (int unsigned i = 0; i < N_UNITS; i++) begin
        if (load[i]) begin
          buf_d[i] = in_pkt[i];
        end
      end
      if (any_grant) begin
        wb_valid_d = 1'b1;
        wb_pkt_d   = buf_q[grant_idx];
        wb_unit_d  = grant_idx;
        rr_ptr_d   = UW'(rr_wrap(32'(grant_idx) + 32'd1, N_UNITS));
      end else if (wb_free) begin
        wb_valid_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_v_q    <= '0;
      rr_ptr_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_pkt_q   <= '0;
      wb_unit_q  <= '0;
      for (int unsigned i = 0; i < N_UNITS; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      buf_v_q    <= buf_v_d;
      rr_ptr_q   <= rr_ptr_d;
      wb_valid_q <= wb_valid_d;
      wb_pkt_q   <= wb_pkt_d;
      wb_unit_q  <= wb_unit_d;
      for (int unsigned i = 0; i < N_UNITS; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_pkt_q.data;
  assign wb_tag   = wb_pkt_q.tag;
  assign wb_unit  = wb_unit_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: hand sequences for reset/latency/reset-abort, a per-cycle
// vector table for ready/valid/unit order, and a tag-keyed scoreboard for data.
module tb_wb_arbiter;

  localparam int NU = 4;
  localparam int DW = 32;
  localparam int TW = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic [NU-1:0]    unit_valid = '0;
  logic [NU*DW-1:0] unit_result = '0;
  logic [NU*TW-1:0] unit_tag = '0;
  logic [NU-1:0]    unit_ready;
  logic             wb_valid;
  logic [DW-1:0]    wb_data;
  logic [TW-1:0]    wb_tag;
  logic [1:0]       wb_unit;
  logic             wb_ready = 1'b1;

  wb_arbiter #(
    .N_UNITS (NU),
    .DATA_W  (DW),
    .TAG_W   (TW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .unit_valid  (unit_valid),
    .unit_result (unit_result),
    .unit_tag    (unit_tag),
    .unit_ready  (unit_ready),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_tag      (wb_tag),
    .wb_unit     (wb_unit),
    .wb_ready    (wb_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       flush;
    logic [3:0] uv;
    logic       wr;
    logic [3:0] ur;
    logic       wv;
    logic [1:0] wu;
  } vec_t;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
    logic [1:0]  unit;
  } sb_t;

  vec_t vt[$];
  sb_t  sbq[$];
  logic [1:0] cnt [NU];

  function automatic vec_t mk(input logic f, input logic [3:0] uv, input logic wr,
                              input logic [3:0] ur, input logic wv, input logic [1:0] wu);
    vec_t v;
    v.flush = f; v.uv = uv; v.wr = wr; v.ur = ur; v.wv = wv; v.wu = wu;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    flush = 1'b0;
    unit_valid = '0;
    wb_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic consume();
    int idx;
    idx = -1;
    for (int j = 0; j < sbq.size(); j++)
      if (idx < 0 && sbq[j].tag == wb_tag) idx = j;
    chk($sformatf("sb_tag_known t=%0h", wb_tag), (idx >= 0) ? 32'd1 : 32'd0, 32'd1);
    if (idx >= 0) begin
      chk($sformatf("sb_data t=%0h", wb_tag), wb_data, sbq[idx].data);
      chk($sformatf("sb_unit t=%0h", wb_tag), 32'(wb_unit), 32'(sbq[idx].unit));
      sbq.delete(idx);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    // ---------------- reset state and single-result latency ----------------
    do_reset();
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_tag", 32'(wb_tag), 32'd0);
    chk("rst_wb_unit", 32'(wb_unit), 32'd0);
    chk("rst_unit_ready", 32'(unit_ready), 32'hF);

    @(negedge clk);
    unit_valid = 4'b0001;
    unit_result = '0;
    unit_result[31:0] = 32'hDEADBEEF;
    unit_tag = 16'h0003;
    wb_ready = 1'b1;
    @(negedge clk);
    unit_valid = '0;
    #1;
    chk("lat_e0_wb_valid", 32'(wb_valid), 32'd0);
    chk("lat_e0_ready0", 32'(unit_ready[0]), 32'd1);
    @(negedge clk);
    #1;
    chk("lat_e1_wb_valid", 32'(wb_valid), 32'd1);
    chk("lat_e1_wb_data", wb_data, 32'hDEADBEEF);
    chk("lat_e1_wb_tag", 32'(wb_tag), 32'd3);
    chk("lat_e1_wb_unit", 32'(wb_unit), 32'd0);
    chk("lat_e1_ready0", 32'(unit_ready[0]), 32'd1);
    @(negedge clk);
    #1;
    chk("lat_drained", 32'(wb_valid), 32'd0);

    // ---------------- table-driven cycles with scoreboard ----------------
    // fields: flush, unit_valid, wb_ready, exp unit_ready, exp wb_valid, exp wb_unit
    vt.push_back(mk(0, 4'b1111, 1, 4'b1111, 0, 0)); // all four units at once
    vt.push_back(mk(0, 4'b0000, 1, 4'b0001, 0, 0));
    vt.push_back(mk(0, 4'b0000, 1, 4'b0011, 1, 0));
    vt.push_back(mk(0, 4'b0000, 1, 4'b0111, 1, 1));
    vt.push_back(mk(0, 4'b0000, 1, 4'b1111, 1, 2));
    vt.push_back(mk(0, 4'b0000, 1, 4'b1111, 1, 3));
    vt.push_back(mk(0, 4'b0101, 1, 4'b1111, 0, 0)); // stall sequence
    vt.push_back(mk(0, 4'b0000, 1, 4'b1011, 0, 0));
    vt.push_back(mk(0, 4'b1010, 0, 4'b1011, 1, 0));
    vt.push_back(mk(0, 4'b0000, 0, 4'b0001, 1, 0));
    vt.push_back(mk(0, 4'b0000, 0, 4'b0001, 1, 0));
    vt.push_back(mk(0, 4'b0000, 1, 4'b0011, 1, 0));
    vt.push_back(mk(0, 4'b0000, 1, 4'b0111, 1, 1));
    vt.push_back(mk(0, 4'b0000, 1, 4'b1111, 1, 2));
    vt.push_back(mk(0, 4'b0000, 1, 4'b1111, 1, 3));
    vt.push_back(mk(0, 4'b0010, 1, 4'b1111, 0, 0)); // move rr_ptr to 2
    vt.push_back(mk(0, 4'b0000, 1, 4'b1111, 0, 0));
    vt.push_back(mk(0, 4'b0110, 1, 4'b1111, 1, 1)); // units 1,2 streaming
    vt.push_back(mk(0, 4'b0110, 1, 4'b1101, 0, 0));
    vt.push_back(mk(0, 4'b0110, 1, 4'b1011, 1, 2));
    vt.push_back(mk(0, 4'b0110, 1, 4'b1101, 1, 1));
    vt.push_back(mk(0, 4'b0110, 1, 4'b1011, 1, 2));
    vt.push_back(mk(0, 4'b0110, 1, 4'b1101, 1, 1));
    vt.push_back(mk(0, 4'b0000, 1, 4'b1011, 1, 2));
    vt.push_back(mk(0, 4'b0000, 1, 4'b1111, 1, 1));
    vt.push_back(mk(0, 4'b0000, 1, 4'b1111, 1, 2));
    vt.push_back(mk(0, 4'b1001, 1, 4'b1111, 0, 0)); // flush sequence
    vt.push_back(mk(0, 4'b1000, 1, 4'b1110, 0, 0));
    vt.push_back(mk(1, 4'b0010, 0, 4'b0110, 1, 3));
    vt.push_back(mk(0, 4'b0000, 1, 4'b1111, 0, 0));
    vt.push_back(mk(0, 4'b1001, 1, 4'b1111, 0, 0));
    vt.push_back(mk(0, 4'b0000, 1, 4'b0111, 0, 0));
    vt.push_back(mk(0, 4'b0000, 1, 4'b1111, 1, 0));
    vt.push_back(mk(0, 4'b0000, 1, 4'b1111, 1, 3));
    vt.push_back(mk(0, 4'b0000, 1, 4'b1111, 0, 0));

    do_reset();
    for (int i = 0; i < NU; i++) cnt[i] = '0;
    for (int k = 0; k < vt.size(); k++) begin
      @(negedge clk);
      flush = vt[k].flush;
      unit_valid = vt[k].uv;
      wb_ready = vt[k].wr;
      for (int i = 0; i < NU; i++) begin
        unit_tag[i*TW +: TW] = {2'(i), cnt[i]};
        unit_result[i*DW +: DW] = {8'hC0, 8'(i), 16'(k)};
      end
      #1;
      chk($sformatf("v%0d unit_ready", k), 32'(unit_ready), 32'(vt[k].ur));
      chk($sformatf("v%0d wb_valid", k), 32'(wb_valid), 32'(vt[k].wv));
      if (vt[k].wv) chk($sformatf("v%0d wb_unit", k), 32'(wb_unit), 32'(vt[k].wu));
      if (wb_valid && wb_ready) consume();
      if (vt[k].flush) begin
        sbq.delete();
      end else begin
        for (int i = 0; i < NU; i++) begin
          if (vt[k].uv[i] && vt[k].ur[i]) begin
            sbq.push_back('{tag: {2'(i), cnt[i]}, data: {8'hC0, 8'(i), 16'(k)}, unit: 2'(i)});
            cnt[i] = cnt[i] + 2'd1;
          end
        end
      end
    end
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    // ---------------- reset abort with full buffers ----------------
    @(negedge clk);
    flush = 1'b0;
    unit_valid = 4'b1111;
    wb_ready = 1'b1;
    @(negedge clk);
    unit_valid = '0;
    wb_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_pre_wb_valid", 32'(wb_valid), 32'd1);
    chk("abort_pre_ready", 32'(unit_ready), 32'b0001);
    reset = 1'b0;
    #1;
    chk("abort_wb_valid", 32'(wb_valid), 32'd0);
    chk("abort_wb_data", wb_data, 32'd0);
    chk("abort_wb_tag", 32'(wb_tag), 32'd0);
    chk("abort_wb_unit", 32'(wb_unit), 32'd0);
    chk("abort_ready", 32'(unit_ready), 32'hF);
    @(negedge clk);
    reset = 1'b1;
    wb_ready = 1'b1;
    unit_valid = 4'b0100;
    unit_result[2*DW +: DW] = 32'h600DF00D;
    unit_tag[2*TW +: TW] = 4'h9;
    seen = 0;
    for (int c = 1; c <= 6 && seen == 0; c++) begin
      @(negedge clk);
      unit_valid = '0;
      #1;
      if (wb_valid) seen = c;
    end
    chk("abort_new_latency", 32'(seen), 32'd2);
    if (seen != 0) begin
      chk("abort_new_unit", 32'(wb_unit), 32'd2);
      chk("abort_new_data", wb_data, 32'h600DF00D);
      chk("abort_new_tag", 32'(wb_tag), 32'h9);
    end
    @(negedge clk);
    #1;
    chk("abort_no_stale", 32'(wb_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
